// File: rtl/mac_pkg.sv
// Shared MAC definitions: TX scheduler state encoding, frame-length defaults
// and line-coding constants used by both the TX and RX paths.
package mac_pkg;

   localparam int unsigned MIN_LEN_DEF    = 60;
   localparam int unsigned MAX_LEN_DEF    = 1514;
   localparam int unsigned IPG_CYCLES_DEF = 12;

   // Byte counter covers MAX_LEN up to 2047 without wrapping.
   localparam int unsigned CNT_W = 11;
   localparam int unsigned GAP_W = 16;

   localparam int unsigned PREAMBLE_LEN  = 7;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_XFER  = 3'd1,
      ST_PAD   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_GAP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/mac_tx_rr_arb.sv
// Two-way round-robin arbiter; the grant and last-grant pointer only move
// when the scheduler leaves IDLE for a new frame.
module mac_tx_rr_arb (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic grant
);

   logic last_q;
   logic pick_c;

   // On a tie the requester not served last wins.
   always_comb begin
      pick_c = req1;
      if (req0 && req1) begin
         pick_c = ~last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
         grant  <= 1'b0;
      end else if (take) begin
         last_q <= pick_c;
         grant  <= pick_c;
      end
   end

endmodule

// File: rtl/mac_tx_sched.sv
// Frame-granular TX scheduler for two sources: pads short frames, truncates
// long ones and enforces the inter-packet gap ahead of the MAC framer.
module mac_tx_sched
   import mac_pkg::*;
#(
   parameter int unsigned MIN_LEN    = MIN_LEN_DEF,
   parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
   parameter int unsigned IPG_CYCLES = IPG_CYCLES_DEF
) (
   input  logic       in_txc,
   input  logic       in_rst,
   input  logic       in_req0_valid,
   input  logic [7:0] in_req0_data,
   input  logic       in_req0_last,
   output logic       out_req0_ready,
   input  logic       in_req1_valid,
   input  logic [7:0] in_req1_data,
   input  logic       in_req1_last,
   output logic       out_req1_ready,
   output logic       out_mac_valid,
   output logic [7:0] out_mac_data,
   output logic       out_mac_last,
   input  logic       in_mac_ready,
   output logic       out_grant,
   output logic       out_busy,
   output logic       out_trunc
);

   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
   localparam logic [GAP_W-1:0] IPG_LOAD = GAP_W'(IPG_CYCLES);

   tx_state_e        state;
   tx_state_e        state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_d;
   logic             trunc_d;
   logic             grant;
   logic             arb_take;
   logic             sel_valid;
   logic             sel_last;
   logic             sel_ready;
   logic [7:0]       sel_data;

   assign sel_valid = grant ? in_req1_valid : in_req0_valid;
   assign sel_last  = grant ? in_req1_last  : in_req0_last;
   assign sel_data  = grant ? in_req1_data  : in_req0_data;
   assign cnt_inc   = cnt + CNT_W'(1);
   assign arb_take  = (state == ST_IDLE) && (in_req0_valid || in_req1_valid);
   assign out_grant = grant;
   assign out_busy  = (state != ST_IDLE);

   mac_tx_rr_arb u_arb (
      .clk   (in_txc),
      .rst   (in_rst),
      .req0  (in_req0_valid),
      .req1  (in_req1_valid),
      .take  (arb_take),
      .grant (grant)
   );

   always_ff @(posedge in_txc) begin
      if (in_rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         gap_cnt   <= '0;
         out_trunc <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         gap_cnt   <= gap_d;
         out_trunc <= trunc_d;
      end
   end

   always_comb begin
      state_d        = state;
      cnt_d          = cnt;
      gap_d          = gap_cnt;
      trunc_d        = 1'b0;
      sel_ready      = 1'b0;
      out_mac_valid  = 1'b0;
      out_mac_data   = 8'h00;
      out_mac_last   = 1'b0;
      out_req0_ready = 1'b0;
      out_req1_ready = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (arb_take) begin
               state_d = ST_XFER;
               cnt_d   = '0;
            end
         end

         ST_XFER: begin
            out_mac_valid = sel_valid;
            out_mac_data  = sel_data;
            sel_ready     = in_mac_ready;
            if (sel_valid && in_mac_ready) begin
               cnt_d = cnt_inc;
               if (sel_last && (cnt_inc >= MIN_CNT)) begin
                  out_mac_last = 1'b1;
                  state_d      = ST_GAP;
                  gap_d        = IPG_LOAD;
               end else if (sel_last) begin
                  state_d = ST_PAD;
               end else if (cnt_inc == MAX_CNT) begin
                  out_mac_last = 1'b1;
                  trunc_d      = 1'b1;
                  state_d      = ST_DRAIN;
               end
            end
         end

         // Zero fill up to the minimum length; the source is already done.
         ST_PAD: begin
            out_mac_valid = 1'b1;
            if (in_mac_ready) begin
               cnt_d = cnt_inc;
               if (cnt_inc == MIN_CNT) begin
                  out_mac_last = 1'b1;
                  state_d      = ST_GAP;
                  gap_d        = IPG_LOAD;
               end
            end
         end

         // Swallow the tail of a truncated frame without touching the framer.
         ST_DRAIN: begin
            sel_ready = 1'b1;
            if (sel_valid && sel_last) begin
               state_d = ST_GAP;
               gap_d   = IPG_LOAD;
            end
         end

         ST_GAP: begin
            if (gap_cnt > GAP_W'(1)) begin
               gap_d = gap_cnt - GAP_W'(1);
            end else begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      out_req0_ready = sel_ready & ~grant;
      out_req1_ready = sel_ready & grant;
   end

endmodule

// File: tb/tb_mac_tx_sched.sv
// Scoreboard bench for mac_tx_sched: expected framer bytes are queued when
// frames are issued and retired as the framer handshakes them.
module tb_mac_tx_sched;

   localparam int MIN_LEN = 60;
   localparam int MAX_LEN = 1514;
   localparam int IPG     = 12;
   localparam int BIG     = 100000;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       grant;
      logic       pad;
      logic       trunc;
   } exp_t;

   logic       in_txc;
   logic       in_rst;
   logic       in_req0_valid, in_req1_valid;
   logic [7:0] in_req0_data, in_req1_data;
   logic       in_req0_last, in_req1_last;
   logic       out_req0_ready, out_req1_ready;
   logic       out_mac_valid;
   logic [7:0] out_mac_data;
   logic       out_mac_last;
   logic       in_mac_ready;
   logic       out_grant, out_busy, out_trunc;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_hs_edge = 0;
   int   trunc_edge = -1;
   int   trunc_cnt = 0;
   bit   rand_ready = 1'b0;

   mac_tx_sched dut (
      .in_txc         (in_txc),
      .in_rst         (in_rst),
      .in_req0_valid  (in_req0_valid),
      .in_req0_data   (in_req0_data),
      .in_req0_last   (in_req0_last),
      .out_req0_ready (out_req0_ready),
      .in_req1_valid  (in_req1_valid),
      .in_req1_data   (in_req1_data),
      .in_req1_last   (in_req1_last),
      .out_req1_ready (out_req1_ready),
      .out_mac_valid  (out_mac_valid),
      .out_mac_data   (out_mac_data),
      .out_mac_last   (out_mac_last),
      .in_mac_ready   (in_mac_ready),
      .out_grant      (out_grant),
      .out_busy       (out_busy),
      .out_trunc      (out_trunc)
   );

   initial begin
      in_txc = 1'b0;
      forever #5 in_txc = ~in_txc;
   end

   always @(posedge in_txc) cyc <= cyc + 1;

   initial begin
      in_mac_ready = 1'b1;
      forever begin
         @(posedge in_txc);
         #1;
         in_mac_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] byte_of(input int seed, input int i);
      return 8'(seed * 37 + i * 13 + i / 7 + 1);
   endfunction

   // Reference view of what the framer must see for a source frame of len bytes.
   task automatic expect_frame(input bit req, input int len, input int seed, input int limit);
      int   outlen;
      exp_t e;
      outlen = (len < MIN_LEN) ? MIN_LEN : ((len > MAX_LEN) ? MAX_LEN : len);
      for (int i = 0; i < outlen && i < limit; i++) begin
         e.data  = (i < len) ? byte_of(seed, i) : 8'h00;
         e.last  = (i == outlen - 1);
         e.grant = req;
         e.pad   = (i >= len);
         e.trunc = (len > MAX_LEN) && (i == outlen - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic set_req(input bit req, input logic v, input logic [7:0] d, input logic l);
      if (req) begin
         in_req1_valid = v; in_req1_data = d; in_req1_last = l;
      end else begin
         in_req0_valid = v; in_req0_data = d; in_req0_last = l;
      end
   endtask

   // Offers bytes 0..stop-1; leaves the source valid when stopped early.
   task automatic drive_frame(input bit req, input int len, input int seed, input bit gaps, input int stop);
      int waitc;
      for (int i = 0; i < len && i < stop; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            set_req(req, 1'b0, 8'h00, 1'b0);
            repeat ($urandom_range(1, 3)) @(posedge in_txc);
            #1;
         end
         set_req(req, 1'b1, byte_of(seed, i), (i == len - 1));
         waitc = 0;
         @(negedge in_txc);
         while (!(req ? out_req1_ready : out_req0_ready) && waitc < 4000) begin
            waitc++;
            @(negedge in_txc);
         end
         if (waitc >= 4000) begin
            check_eq("req_ready_timeout", waitc, 0);
            set_req(req, 1'b0, 8'h00, 1'b0);
            return;
         end
         @(posedge in_txc);
         #1;
      end
      if (stop >= len) set_req(req, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((out_busy || exp_q.size() != 0) && n < 5000) begin
         @(negedge in_txc);
         n++;
      end
      check_eq({tag, "_queue"}, exp_q.size(), 0);
      check_eq({tag, "_busy"}, out_busy, 0);
      @(posedge in_txc);
      #1;
   endtask

   // Retire one expected entry per framer handshake.
   always @(negedge in_txc) begin
      exp_t e;
      if (!in_rst && out_mac_valid && in_mac_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_byte", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check_eq("data", out_mac_data, e.data);
            check_eq("last", out_mac_last, e.last);
            check_eq("grant", out_grant, e.grant);
            if (e.pad) check_eq("pad_readies", {out_req0_ready, out_req1_ready}, 0);
            if (e.trunc) trunc_edge = cyc + 1;
            last_hs_edge = cyc + 1;
         end
      end
      if (!in_rst && out_trunc) begin
         trunc_cnt++;
         check_eq("trunc_cycle", cyc, trunc_edge);
      end
   end

   initial begin
      int n;
      in_rst = 1'b1;
      set_req(1'b0, 1'b0, 8'h00, 1'b0);
      set_req(1'b1, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge in_txc);
      @(negedge in_txc);
      check_eq("rst_valid", out_mac_valid, 0);
      check_eq("rst_last", out_mac_last, 0);
      check_eq("rst_data", out_mac_data, 0);
      check_eq("rst_ready", {out_req0_ready, out_req1_ready}, 0);
      check_eq("rst_busy", out_busy, 0);
      check_eq("rst_trunc", out_trunc, 0);
      check_eq("rst_grant", out_grant, 0);
      @(posedge in_txc);
      #1;
      in_rst = 1'b0;
      @(posedge in_txc);
      #1;

      // Tie after reset: req0 first, then strict alternation.
      expect_frame(1'b0, 60, 1, BIG);
      expect_frame(1'b1, 61, 2, BIG);
      expect_frame(1'b0, 70, 3, BIG);
      expect_frame(1'b1, 60, 4, BIG);
      fork
         begin drive_frame(1'b0, 60, 1, 1'b0, BIG); drive_frame(1'b0, 70, 3, 1'b0, BIG); end
         begin drive_frame(1'b1, 61, 2, 1'b0, BIG); drive_frame(1'b1, 60, 4, 1'b0, BIG); end
      join
      wait_idle("alternate");

      // 64-byte frame and inter-packet gap length.
      expect_frame(1'b0, 64, 5, BIG);
      drive_frame(1'b0, 64, 5, 1'b0, BIG);
      n = 0;
      do begin
         @(negedge in_txc);
         n++;
      end while (out_busy && n < 100);
      check_eq("ipg_idle_cycle", cyc - last_hs_edge, IPG);
      wait_idle("frame64");

      // Short frame padded to the minimum.
      expect_frame(1'b1, 20, 6, BIG);
      drive_frame(1'b1, 20, 6, 1'b0, BIG);
      wait_idle("pad20");

      // Over-length frame truncated, remainder drained.
      trunc_cnt = 0;
      expect_frame(1'b0, 1600, 7, BIG);
      drive_frame(1'b0, 1600, 7, 1'b0, BIG);
      wait_idle("trunc1600");
      check_eq("trunc_pulses", trunc_cnt, 1);

      // Backpressure and source bubbles.
      rand_ready = 1'b1;
      expect_frame(1'b1, 100, 8, BIG);
      drive_frame(1'b1, 100, 8, 1'b1, BIG);
      rand_ready = 1'b0;
      wait_idle("random100");

      // Reset mid-frame after 30 bytes; req0 was last granted.
      expect_frame(1'b0, 100, 9, 30);
      drive_frame(1'b0, 100, 9, 1'b0, 30);
      in_rst = 1'b1;
      @(posedge in_txc);
      #1;
      in_rst = 1'b0;
      set_req(1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge in_txc);
      check_eq("mid_rst_valid", out_mac_valid, 0);
      check_eq("mid_rst_ready", {out_req0_ready, out_req1_ready}, 0);
      check_eq("mid_rst_busy", out_busy, 0);
      check_eq("mid_rst_trunc", out_trunc, 0);
      check_eq("mid_rst_queue", exp_q.size(), 0);
      @(posedge in_txc);
      #1;

      // Pointer back to 1: req0 wins the tie; fresh count gives last on byte 60.
      expect_frame(1'b0, 60, 10, BIG);
      expect_frame(1'b1, 62, 11, BIG);
      fork
         drive_frame(1'b0, 60, 10, 1'b0, BIG);
         drive_frame(1'b1, 62, 11, 1'b0, BIG);
      join
      wait_idle("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

endmodule
